// File: rtl/dispense_sequencer.sv
// rtl/dispense_sequencer.sv - grain gate sequencer for one dispense order
// Times open/pause phases from the periodic timer tick and gates the timer enable.
module dispense_sequencer #(
  parameter int MAX_PORTIONS      = 9,
  parameter int TICKS_PER_PORTION = 2,
  parameter int PAUSE_TICKS       = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] portions,
  input  logic       abort,
  input  logic       jam,
  input  logic       fault_clr,
  input  logic       tick,
  output logic       timer_run,
  output logic       gate_open,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] portions_left
);

  localparam int CNT_MAX = (TICKS_PER_PORTION > PAUSE_TICKS) ? TICKS_PER_PORTION : PAUSE_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] OPEN_LAST  = CW'(TICKS_PER_PORTION - 1);
  localparam logic [CW-1:0] PAUSE_LAST = CW'(PAUSE_TICKS - 1);
  localparam logic [3:0]    MAX_P      = 4'(MAX_PORTIONS);

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_PAUSE, S_FAULT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    left_d;
  logic          done_d;
  logic          tick_en;

  // A tick only counts while the timer is actually enabled.
  assign tick_en = tick & timer_run;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = portions_left;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (portions != 4'd0 && portions <= MAX_P) begin
            state_d = S_OPEN;
            left_d  = portions;
            cnt_d   = '0;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_OPEN: begin
        if (jam) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (abort) begin
          state_d = S_IDLE;
          left_d  = 4'd0;
          cnt_d   = '0;
        end else if (tick_en) begin
          if (cnt_q == OPEN_LAST) begin
            cnt_d  = '0;
            left_d = portions_left - 4'd1;
            if (portions_left == 4'd1) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_PAUSE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        // Gate is closed here, so jam is deliberately not examined.
        if (abort) begin
          state_d = S_IDLE;
          left_d  = 4'd0;
          cnt_d   = '0;
        end else if (tick_en) begin
          if (cnt_q == PAUSE_LAST) begin
            cnt_d   = '0;
            state_d = S_OPEN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          state_d = S_IDLE;
          left_d  = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      portions_left <= 4'd0;
      done          <= 1'b0;
      gate_open     <= 1'b0;
      timer_run     <= 1'b0;
      busy          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      portions_left <= left_d;
      done          <= done_d;
      gate_open     <= (state_d == S_OPEN);
      timer_run     <= (state_d == S_OPEN) || (state_d == S_PAUSE);
      busy          <= (state_d == S_OPEN) || (state_d == S_PAUSE);
      fault         <= (state_d == S_FAULT);
    end
  end

endmodule

// File: tb/tb_dispense_sequencer.sv
// tb/tb_dispense_sequencer.sv - self-checking bench for dispense_sequencer
// Output vector layout: {gate_open, timer_run, busy, done, fault, portions_left}.
module tb_dispense_sequencer;

  localparam int MAXP = 9;
  localparam int TPP  = 2;
  localparam int PT   = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, abort = 1'b0, jam = 1'b0, fault_clr = 1'b0, tick = 1'b0;
  logic [3:0] portions = 4'd0;
  logic       timer_run, gate_open, busy, done, fault;
  logic [3:0] portions_left;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  dispense_sequencer #(
    .MAX_PORTIONS(MAXP), .TICKS_PER_PORTION(TPP), .PAUSE_TICKS(PT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .portions(portions), .abort(abort),
    .jam(jam), .fault_clr(fault_clr), .tick(tick), .timer_run(timer_run),
    .gate_open(gate_open), .busy(busy), .done(done), .fault(fault),
    .portions_left(portions_left)
  );

  // Reference model: an order is a sequence of phases 0..2N-2, even = open, odd = pause.
  bit m_active, m_faulted, m_done;
  int m_n, m_p, m_t, m_hold;

  function automatic int m_left();
    if (m_active)  return m_n - (m_p + 1) / 2;
    if (m_faulted) return m_hold;
    return 0;
  endfunction

  function automatic logic [8:0] model_vec();
    logic [3:0] l;
    logic       g;
    l = 4'(m_left());
    g = m_active && (m_p % 2 == 0);
    return {g, m_active, m_active, m_done, m_faulted, l};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {gate_open, timer_run, busy, done, fault, portions_left};
  endfunction

  function automatic void model_reset();
    m_active = 0; m_faulted = 0; m_done = 0; m_n = 0; m_p = 0; m_t = 0; m_hold = 0;
  endfunction

  function automatic void model_step(input logic s, input logic [3:0] p,
                                     input logic a, input logic j, input logic fc, input logic tk);
    bit is_open;
    int len;
    m_done = 0;
    if (m_faulted) begin
      if (fc) begin m_faulted = 0; m_hold = 0; end
    end else if (!m_active) begin
      if (s) begin
        if (p >= 1 && p <= MAXP) begin m_active = 1; m_n = int'(p); m_p = 0; m_t = 0; end
        else begin m_faulted = 1; m_hold = 0; end
      end
    end else begin
      is_open = (m_p % 2 == 0);
      len = is_open ? TPP : PT;
      if (j && is_open) begin
        m_hold = m_left(); m_active = 0; m_faulted = 1;
      end else if (a) begin
        m_active = 0;
      end else if (tk) begin
        m_t++;
        if (m_t == len) begin
          m_t = 0;
          if (m_p == 2 * m_n - 2) begin m_active = 0; m_done = 1; end
          else m_p++;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic [3:0] p, input logic a,
                      input logic j, input logic fc, input logic tk);
    start = s; portions = p; abort = a; jam = j; fault_clr = fc; tick = tk;
    @(posedge clk);
    model_step(s, p, a, j, fc, tk);
    #1;
    check("model", dut_vec(), model_vec());
    if (done === 1'b1) done_seen++;
    start = 1'b0; abort = 1'b0; jam = 1'b0; fault_clr = 1'b0; tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0, 0, 0);
  endtask

  task automatic tk(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0, 0, 1);
  endtask

  typedef struct {
    logic       s;
    logic [3:0] p;
    logic       a, j, fc, t;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic [3:0] p, input logic a, input logic j,
                              input logic fc, input logic t, input logic g, input logic r,
                              input logic b, input logic d, input logic f, input logic [3:0] l);
    vec_t v;
    v.s = s; v.p = p; v.a = a; v.j = j; v.fc = fc; v.t = t;
    v.exp = {g, r, b, d, f, l};
    return v;
  endfunction

  initial begin
    //                s  p      a  j  fc t    g  r  b  d  f  left
    tbl.push_back(mk(1, 4'd3,  0, 0, 0, 0,   1, 1, 1, 0, 0, 4'd3));
    tbl.push_back(mk(0, 4'd0,  0, 0, 0, 1,   1, 1, 1, 0, 0, 4'd3));
    tbl.push_back(mk(0, 4'd0,  0, 0, 0, 1,   0, 1, 1, 0, 0, 4'd2));
    tbl.push_back(mk(0, 4'd0,  0, 0, 0, 1,   1, 1, 1, 0, 0, 4'd2));
    tbl.push_back(mk(0, 4'd0,  0, 0, 0, 0,   1, 1, 1, 0, 0, 4'd2));
    tbl.push_back(mk(0, 4'd0,  0, 0, 0, 1,   1, 1, 1, 0, 0, 4'd2));
    tbl.push_back(mk(0, 4'd0,  0, 0, 0, 1,   0, 1, 1, 0, 0, 4'd1));
    tbl.push_back(mk(0, 4'd0,  0, 0, 0, 1,   1, 1, 1, 0, 0, 4'd1));
    tbl.push_back(mk(0, 4'd0,  0, 0, 0, 1,   1, 1, 1, 0, 0, 4'd1));
    tbl.push_back(mk(0, 4'd0,  0, 0, 0, 1,   0, 0, 0, 1, 0, 4'd0));
    tbl.push_back(mk(0, 4'd0,  0, 0, 0, 1,   0, 0, 0, 0, 0, 4'd0));
    tbl.push_back(mk(1, 4'd0,  0, 0, 0, 0,   0, 0, 0, 0, 1, 4'd0));
    tbl.push_back(mk(1, 4'd1,  1, 0, 0, 0,   0, 0, 0, 0, 1, 4'd0));
    tbl.push_back(mk(0, 4'd0,  0, 0, 1, 0,   0, 0, 0, 0, 0, 4'd0));
    tbl.push_back(mk(1, 4'd10, 0, 0, 0, 0,   0, 0, 0, 0, 1, 4'd0));
    tbl.push_back(mk(0, 4'd0,  0, 0, 1, 0,   0, 0, 0, 0, 0, 4'd0));
    tbl.push_back(mk(1, 4'd9,  0, 0, 0, 0,   1, 1, 1, 0, 0, 4'd9));
    tbl.push_back(mk(0, 4'd0,  1, 0, 0, 0,   0, 0, 0, 0, 0, 4'd0));
    tbl.push_back(mk(1, 4'd1,  0, 0, 0, 0,   1, 1, 1, 0, 0, 4'd1));
    tbl.push_back(mk(0, 4'd0,  0, 1, 0, 1,   0, 0, 0, 0, 1, 4'd1));
    tbl.push_back(mk(0, 4'd0,  0, 0, 1, 0,   0, 0, 0, 0, 0, 4'd0));

    model_reset();
    #1;
    check("reset_state", dut_vec(), 9'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s, tbl[i].p, tbl[i].a, tbl[i].j, tbl[i].fc, tbl[i].t);
      check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end

    // Three portions with a tick every 10 cycles; exactly one done pulse.
    done_seen = 0;
    step(1, 4'd3, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin idle(9); tk(1); end
    idle(2);
    check("done_once", 9'(done_seen), 9'd1);

    // Jam during the second open phase freezes portions_left.
    step(1, 4'd4, 0, 0, 0, 0);
    tk(3); tk(1);
    step(0, 4'd0, 0, 1, 0, 0);
    check("jam_open", dut_vec(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3});
    step(0, 4'd0, 0, 0, 1, 0);
    // Jam during pause is ignored.
    step(1, 4'd4, 0, 0, 0, 0);
    tk(2);
    step(0, 4'd0, 0, 1, 0, 0);
    check("jam_pause", dut_vec(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3});
    step(0, 4'd0, 1, 0, 0, 0);

    // Abort in pause after two portions, later ticks ignored.
    done_seen = 0;
    step(1, 4'd5, 0, 0, 0, 0);
    tk(5);
    step(0, 4'd0, 1, 0, 0, 0);
    check("abort_pause", dut_vec(), 9'd0);
    tk(4);
    check("abort_no_done", 9'(done_seen), 9'd0);

    // Start while busy is ignored; tick+jam together in open gives fault.
    done_seen = 0;
    step(1, 4'd2, 0, 0, 0, 0);
    step(1, 4'd7, 0, 0, 0, 1);
    tk(1);
    step(1, 4'd7, 0, 0, 0, 1);
    tk(2);
    idle(1);
    check("busy_start_done", 9'(done_seen), 9'd1);
    step(1, 4'd3, 0, 0, 0, 0);
    tk(1);
    step(0, 4'd0, 0, 1, 0, 1);
    check("tick_jam", dut_vec(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3});
    step(0, 4'd0, 0, 0, 1, 0);

    // Asynchronous reset between clock edges mid-open.
    step(1, 4'd3, 0, 0, 0, 0);
    tk(1);
    #3 reset = 1'b1;
    #1;
    check("async_reset", dut_vec(), 9'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1, 4'd2, 0, 0, 0, 0);
    tk(5);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      step($urandom_range(0, 3) == 0, rp, $urandom_range(0, 29) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
- Controls the grain gate for one dispense order.
- Accepts an order of N portions.
- Drives the enable input of the downstream periodic tick timer, so the timer runs only while an order is active.
- Consumes the timer's one-cycle tick to time each portion: gate open for TICKS_PER_PORTION ticks, then closed for PAUSE_TICKS ticks.
- Reports busy, done, remaining portions, and latches a fault on a jam or an invalid order.

Parameters:
- MAX_PORTIONS, default 9: largest portion count accepted; valid range 1..15.
- TICKS_PER_PORTION, default 2: timer ticks the gate stays open per portion; must be ≥ 1.
- PAUSE_TICKS, default 1: timer ticks the gate stays closed between portions; must be ≥ 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  order request; sampled only in IDLE
- portions  in  4  requested portion count; sampled with start
- abort  in  1  cancels the active order; level-sampled each cycle
- jam  in  1  gate-jam sensor; already synchronised
- fault_clr  in  1  clears a latched fault
- tick  in  1  one-cycle pulse from the periodic timer
- timer_run  out  1  enable to the timer; the timer holds its count at 0 while this is low
- gate_open  out  1  gate actuator command
- busy  out  1  high in OPEN and PAUSE
- done  out  1  one-cycle pulse when the last portion completes
- fault  out  1  latched error flag
- portions_left  out  4  portions still to dispense

Behaviour:
- Reset: asynchronous. State=IDLE. All outputs 0; portions_left=0; tick counter=0.
- All outputs are registered.
- IDLE:
  - start=1 and 1 ≤ portions ≤ MAX_PORTIONS: go to OPEN next cycle. Load portions_left=portions, tick counter=0, set timer_run=1 and gate_open=1 in the same edge.
  - start=1 with portions=0 or portions > MAX_PORTIONS: go to FAULT; set fault=1.
- OPEN:
  - Each tick increments the tick counter.
  - On the tick that makes the count reach TICKS_PER_PORTION: decrement portions_left, reset counter to 0.
    - If portions_left was 1: go to IDLE, pulse done=1 for one cycle, drop timer_run and gate_open.
    - Otherwise: go to PAUSE, drop gate_open, keep timer_run=1.
- PAUSE:
  - gate_open=0, timer_run=1.
  - On the tick that makes the count reach PAUSE_TICKS: reset counter, go to OPEN, set gate_open=1.
- FAULT:
  - All outputs 0 except fault=1. portions_left holds its value.
  - fault_clr=1: go to IDLE; fault=0, portions_left=0.
- Priority each cycle, highest first:
  1. jam (in OPEN only) → FAULT. gate_open and timer_run drop on the next edge. portions_left holds.
  2. abort (in OPEN or PAUSE) → IDLE. All outputs 0, no done pulse.
  3. tick processing.
- jam in PAUSE is ignored, because the gate is closed.
- start while busy is ignored.
- abort in IDLE or FAULT has no effect.
- A tick while timer_run=0 is ignored in every state.
- Restart latency: from done (back in IDLE), start is accepted on the next cycle. The timer restarts from 0 because timer_run was low for at least one cycle.
- Tick counter width: enough for max(TICKS_PER_PORTION, PAUSE_TICKS). It never wraps, because it is cleared at each terminal count.
- A tick arriving in the same cycle as an OPEN→PAUSE or PAUSE→OPEN transition counts only for the current state.

Test Plan:
1. reset; start with portions=3, TICKS_PER_PORTION=2, PAUSE_TICKS=1; drive tick every 10 cycles → gate_open high for 2 ticks, low for 1 tick, pattern repeated 3 times. portions_left steps 3→2→1→0. done pulses once after the 6th open tick. timer_run low the next cycle.
2. start with portions=0, then portions=10 → fault=1, gate_open never rises. fault_clr → fault=0, IDLE; a following valid start with portions=1 dispenses normally.
3. portions=4; jam asserted during the 2nd OPEN phase → next edge gate_open=0, timer_run=0, fault=1, portions_left=3 held. jam during PAUSE (separate run) → no effect.
4. portions=5; abort during PAUSE after 2 portions → IDLE, all outputs 0, no done. Ticks afterward are ignored.
5. start asserted while busy with a different portions value → ignored, order completes with the original count. tick and jam asserted in the same cycle in OPEN → FAULT wins, portions_left is not decremented.
6. reset asserted mid-OPEN, asynchronously between clock edges → gate_open, timer_run, busy and portions_left all go to 0 immediately. After release, a new start works.
